// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier controller. It borrows the shared EX-stage ALU
// for one add per multiplier bit and returns the low WIDTH bits of a*b.
// When it is not iterating, the ALU sees the EX-stage operands unchanged.
module alu_mul_sequencer #(
  parameter int         WIDTH  = 64,
  parameter int         CNT_W  = 7,
  parameter logic [3:0] OP_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [3:0]       ex_op,
  output logic             ex_stall,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_accNext;
  logic             w_lastIter;

  // Accumulator update for this iteration and the early-exit test: stop once no
  // multiplier bits remain above the current one, or after the top bit.
  always_comb begin
    w_accNext  = r_mplier[0] ? alu_o : r_acc;
    w_lastIter = ((r_mplier >> 1) == '0) || (r_count == CNT_W'(WIDTH - 1));
  end

  // Next-state logic: start is only honoured from IDLE; DONE always lasts one cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (start) w_stateNext = S_ITER;
      S_ITER:  if (w_lastIter) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // ALU operand mux: the sequencer owns the ALU only while iterating.
  always_comb begin
    alu_a  = ex_a;
    alu_b  = ex_b;
    alu_op = ex_op;
    if (r_state == S_ITER) begin
      alu_a  = r_acc;
      alu_b  = r_mcand;
      alu_op = OP_ADD;
    end
  end

  // State register; an asynchronous reset drops any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Datapath: load operands on an accepted start, shift-add while iterating, and
  // capture the last accumulator value (including the final add) as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= mul_a;
            r_mplier <= mul_b;
            r_count  <= '0;
          end
        end
        S_ITER: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (w_lastIter) r_result <= w_accNext;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_ITER);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign ex_stall = (r_state == S_ITER) || ((r_state == S_IDLE) && start);

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier controller that time-shares the single 64-bit EX-stage ALU.
- Computes the low WIDTH bits of a*b (mulld semantics). The low half is identical for signed and unsigned operands.
- Sits between the EX stage and the ALU:
  - When idle, it passes the EX operands and opcode straight through to the ALU.
  - While multiplying, it owns the ALU and stalls EX.

Parameters:
- WIDTH, 64, datapath/operand width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- OP_ADD, 4'b0010, ALU opcode for add (Ain=0, Bin=0, op=10, carry-in 0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request multiply; sampled only in IDLE
- mul_a  in  WIDTH  multiplicand, captured on accepted start
- mul_b  in  WIDTH  multiplier, captured on accepted start
- busy  out  1  high in ITER
- done  out  1  one-cycle pulse in DONE; result valid
- result  out  WIDTH  product low bits; held until next accepted start
- ex_a, ex_b  in  WIDTH  EX-stage ALU operands
- ex_op  in  4  EX-stage ALU opcode
- ex_stall  out  1  EX must hold its instruction
- alu_a, alu_b  out  WIDTH  ALU operand drive
- alu_op  out  4  ALU opcode drive
- alu_o  in  WIDTH  ALU result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, mcand, mplier, count, result all 0; done=0; busy=0. Reset mid-multiply aborts it; no done pulse is produced.
- States: IDLE, ITER, DONE.
- IDLE:
  - If start=1, load mcand=mul_a, mplier=mul_b, acc=0, count=0; next state ITER.
  - Otherwise stay in IDLE.
- ITER, per cycle:
  - Drive alu_a=acc, alu_b=mcand, alu_op=OP_ADD.
  - If mplier[0]=1, acc<=alu_o; else acc holds. The ALU carry-out/Ovf is ignored; the sum wraps mod 2^WIDTH.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Exit to DONE when (mplier>>1)==0 or count==WIDTH-1 (early termination). Otherwise stay in ITER.
- DONE:
  - result<=final acc, registered so it is visible in the DONE cycle. The final-iteration add must be folded in, so result=acc_next of the last ITER cycle, registered on the ITER->DONE edge.
  - done=1 for exactly one cycle; next state IDLE.
  - start is ignored in DONE.
- Latency: ITER cycles = max(1, index of highest set bit of mul_b + 1), then one DONE cycle. Examples:
  - b=0 -> 1 ITER cycle.
  - b=5 -> 3 ITER cycles.
  - b with bit 63 set -> 64 ITER cycles.
- ALU mux:
  - In ITER, alu_* come from the sequencer.
  - In IDLE and DONE, alu_a=ex_a, alu_b=ex_b, alu_op=ex_op (combinational pass-through).
- ex_stall = (state==ITER) | (state==IDLE & start). Combinational, so the multiply instruction holds in EX until done.
- busy = (state==ITER). done and busy are never high together.
- start asserted in ITER or DONE has no effect and is not queued.

Test Plan:
- Reset then idle: rst_n low mid-stream -> all outputs 0. Then with ex_a=7, ex_b=9, ex_op=4'b0010 -> alu_a=7, alu_b=9, alu_op=0010 same cycle; ex_stall=0.
- 6*5: start with a=6, b=5 -> busy for exactly 3 cycles, ex_stall high from the start cycle through the last ITER cycle, done pulse on the 4th cycle after start with result=30, alu_op=0010 during ITER.
- Zero multiplier: a=0x1234, b=0 -> 1 ITER cycle, then done with result=0. Full-width: a=3, b=0x8000_0000_0000_0001 -> 64 ITER cycles, result=0x8000_0000_0000_0003.
- Wrap and sign: a=0xFFFF_FFFF_FFFF_FFFF (-1), b=2 -> result=0xFFFF_FFFF_FFFF_FFFE. a=2^63, b=2 -> result=0 (overflow discarded).
- Ignored start: pulse start again during ITER and during DONE with different operands -> first result is unchanged and no second multiply starts. start one cycle after DONE is accepted normally.
- Reset mid-op: a=3, b=0xFF, drop rst_n after 4 ITER cycles -> immediate IDLE, done never pulses, result=0, ALU returns to pass-through.
